// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, baud codes
// and the default busy-rise timeout.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [2:0] BAUD_0 = 3'd0;
  localparam logic [2:0] BAUD_1 = 3'd1;
  localparam logic [2:0] BAUD_2 = 3'd2;
  localparam logic [2:0] BAUD_3 = 3'd3;
  localparam logic [2:0] BAUD_4 = 3'd4;
  localparam logic [2:0] BAUD_5 = 3'd5;
  localparam logic [2:0] BAUD_6 = 3'd6;
  localparam logic [2:0] BAUD_7 = 3'd7;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/uart_tx_scheduler_rr_select.sv
// Combinational round-robin picker: first set req_valid bit at or above rr_ptr,
// wrapping around to bit 0.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PW-1:0]    rr_ptr,
  output logic             any_grant,
  output logic [PW-1:0]    winner
);

  localparam logic [PW:0] N_W = (PW+1)'(N_REQ);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [PW-1:0]      offset;
  logic [PW:0]        sum;

  assign doubled = {req_valid, req_valid};

  // rotated[0] is the requester rr_ptr points at, so the lowest set bit wins.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rotated[gi] = doubled[gi + int'(rr_ptr)];
  end

  always_comb begin
    any_grant = |req_valid;
    offset    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) offset = PW'(k);
    end
    sum    = {1'b0, rr_ptr} + {1'b0, offset};
    winner = (sum >= N_W) ? (sum[PW-1:0] - N_W[PW-1:0]) : sum[PW-1:0];
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that hands bytes from N_REQ requesters to a single UART
// transmitter, one frame at a time, with a timeout on the busy handshake.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic [2:0]         cfg_baud,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  input  logic               tx_busy,
  output logic [7:0]         tx_data,
  output logic               tx_wr,
  output logic               tx_en,
  output logic [2:0]         baud_select,
  output logic [2:0]         active_id,
  output logic               idle,
  output logic               timeout_err
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_TOP  = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);

  state_t        state_reg, state_next;
  logic [PW-1:0] rr_ptr_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic [7:0]    tx_data_reg;
  logic [2:0]    active_id_reg;
  logic [2:0]    baud_reg;
  logic          tx_en_reg;
  logic          timeout_err_reg;
  logic          warmup_reg;

  logic          any_grant;
  logic [PW-1:0] sel_winner;
  logic [7:0]    sel_data;
  logic          grant;
  logic          timeout_hit;
  logic          load_cfg;

  rr_select #(.N_REQ(N_REQ), .PW(PW)) u_rr_select (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .any_grant (any_grant),
    .winner    (sel_winner)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_winner == PW'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant       = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        // warmup_reg holds off grants for the first edge after reset release
        if (!warmup_reg && cfg_en && !tx_busy && any_grant) begin
          grant      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt_reg == CNT_TOP) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Config is sampled on every edge that leaves the FSM in IDLE, so it takes
  // effect on IDLE entry and is frozen for the whole frame.
  assign load_cfg = (state_reg == IDLE) || (state_next == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      wait_cnt_reg    <= '0;
      tx_data_reg     <= '0;
      active_id_reg   <= '0;
      baud_reg        <= '0;
      tx_en_reg       <= 1'b0;
      timeout_err_reg <= 1'b0;
      warmup_reg      <= 1'b1;
    end else begin
      state_reg       <= state_next;
      timeout_err_reg <= timeout_hit;
      warmup_reg      <= 1'b0;
      if (grant) begin
        tx_data_reg   <= sel_data;
        active_id_reg <= 3'(sel_winner);
        rr_ptr_reg    <= (sel_winner == LAST_REQ) ? '0 : sel_winner + 1'b1;
        wait_cnt_reg  <= '0;
      end else if (state_reg != IDLE && wait_cnt_reg != CNT_TOP) begin
        wait_cnt_reg  <= wait_cnt_reg + 1'b1;
      end
      if (load_cfg) begin
        baud_reg  <= cfg_baud;
        tx_en_reg <= cfg_en;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
    assign req_ack[gi] = (state_reg == ISSUE) && (active_id_reg == 3'(gi));
  end

  assign tx_wr       = (state_reg == ISSUE);
  assign idle        = (state_reg == IDLE);
  assign tx_data     = tx_data_reg;
  assign active_id   = active_id_reg;
  assign baud_select = baud_reg;
  assign tx_en       = tx_en_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, setting the number of byte requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, setting the clk cycles to wait for tx_busy to rise after a write.
REQ-003 The block SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port cfg_en  input  1  global transmit enable.
REQ-006 The block SHALL have port cfg_baud  input  3  requested baud_select code.
REQ-007 The block SHALL have port req_valid  input  N_REQ  per-requester byte-pending flag.
REQ-008 The block SHALL have port req_data  input  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-009 The block SHALL have port req_ack  output  N_REQ  one-cycle pulse when requester i's byte is issued.
REQ-010 The block SHALL have port tx_busy  input  1  transmitter busy status.
REQ-011 The block SHALL have ports tx_data output 8, tx_wr output 1, tx_en output 1 and baud_select output 3, all driving the transmitter.
REQ-012 The block SHALL have ports active_id output 3 (last granted requester), idle output 1 (state is IDLE) and timeout_err output 1 (one-cycle error pulse).

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-014 Grant condition in IDLE: cfg_en=1, tx_busy=0 and |req_valid=1. When met, the winner SHALL be the first set req_valid bit searching upward from rr_ptr with wrap-around.
REQ-015 On grant, the block SHALL register tx_data from the winner's slice and active_id, set rr_ptr to (winner+1) mod N_REQ, and move to ISSUE.
REQ-016 In ISSUE, tx_wr and req_ack[winner] SHALL both be high for exactly one cycle, and the next state SHALL be WAIT_BUSY. Latency SHALL be 1 cycle from the sampling edge to tx_wr.
REQ-017 In WAIT_BUSY, tx_busy=1 SHALL go to WAIT_DONE. Otherwise, when the wait counter reaches TIMEOUT-1, the block SHALL pulse timeout_err for one cycle and return to IDLE.
REQ-018 In WAIT_DONE, tx_busy=0 SHALL return to IDLE, and no new grant SHALL occur in that same cycle.
REQ-019 baud_select and tx_en SHALL load from cfg_baud and cfg_en only while in IDLE, and SHALL stay frozen in every other state, so a frame never changes rate.
REQ-020 If cfg_en falls mid-frame, the current frame SHALL complete, tx_en SHALL drop on IDLE entry, and no further grants SHALL occur.
REQ-021 A requester deasserting req_valid before its grant SHALL be skipped, with no ack. At most one req_ack bit SHALL be high in any cycle.
REQ-022 The wait counter SHALL clear on ISSUE entry and SHALL saturate at TIMEOUT-1.
REQ-023 tx_data SHALL hold its value until the next grant.
REQ-024 idle SHALL equal (state==IDLE).

Reset
REQ-025 While rst=1, the block SHALL enter IDLE, abandoning any frame in progress.
REQ-026 Reset values SHALL be: rr_ptr=0 and wait counter=0; tx_data=0, tx_wr=0, tx_en=0, baud_select=0, req_ack=0, active_id=0, timeout_err=0 and idle=1.
REQ-027 The first grant after reset release SHALL occur no earlier than the second clk edge after rst falls.

Structure
REQ-028 Package uart_ctrl_pkg SHALL hold the FSM state encoding, the baud code constants BAUD_0..BAUD_7 (3'd0..3'd7) and the default TIMEOUT value.
REQ-029 Round-robin winner selection SHALL be a separate combinational sub-module rr_select, with inputs req_valid and rr_ptr and outputs any_grant and winner index.
REQ-030 The RTL SHALL total 120-400 lines.

Verification
REQ-031 Single requester: req_valid=4'b0001 with byte 8'hAA, tx_busy pulled high 2 cycles after tx_wr for 100 cycles -> exactly one tx_wr, tx_data=8'hAA, req_ack=4'b0001 in the same cycle.
REQ-032 All requesters continuously valid with bytes AA/55/CC/89 -> issue order 0,1,2,3,0 and rr_ptr wraps to 0 after requester 3.
REQ-033 cfg_baud changed 3'd1 to 3'd5 during WAIT_DONE -> baud_select stays 3'd1 until IDLE, then reads 3'd5 before the next tx_wr.
REQ-034 tx_busy held 0 after tx_wr -> timeout_err pulses exactly 64 cycles after ISSUE, state returns to IDLE and the next requester is granted.
REQ-035 rst=1 asserted during WAIT_DONE -> next cycle all outputs are at reset values, idle=1 and rr_ptr=0.
REQ-036 cfg_en=0 with req_valid=4'b1111 -> no tx_wr and no req_ack for 200 cycles, and tx_en=0.
